// File: rtl/score_bcd.sv
// Binary-to-packed-BCD converter for both player scores (shared sequential double-dabble).
// Latency: 2*IN_WIDTH cycles from the capture edge to the bcd1/bcd2/valid update.
// Backpressure: none; requests while busy collapse into one follow-up conversion.
//
// Ports: clock, reset (sync, active-high), update_score (1-cycle request),
//        score1/score2 (binary in), bcd1/bcd2 (packed BCD, LSD in [3:0]),
//        busy (converting), valid (1-cycle strobe when bcd1/bcd2 update).
// Optional: define SCORE_BCD_SEG_EN to add seg1/seg2 active-low 7-seg outputs
//           (gfedcba per digit, LSD in [6:0]).
module score_bcd #(
    parameter int IN_WIDTH = 4,
    parameter int DIGITS   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  update_score,
    input  logic [IN_WIDTH-1:0]   score1,
    input  logic [IN_WIDTH-1:0]   score2,
    output logic [4*DIGITS-1:0]   bcd1,
    output logic [4*DIGITS-1:0]   bcd2,
    output logic                  busy,
    output logic                  valid
`ifdef SCORE_BCD_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg1,
    output logic [7*DIGITS-1:0]   seg2
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + IN_WIDTH;
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV1, CONV2, DONE} state_t;

    state_t            state_q,   state_d;
    logic              pending_q, pending_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [IN_WIDTH-1:0] snap2_q, snap2_d;
    logic [SW-1:0]     shift_q,   shift_d;
    logic [BW-1:0]     temp1_q,   temp1_d;
    logic [BW-1:0]     bcd1_q,    bcd1_d;
    logic [BW-1:0]     bcd2_q,    bcd2_d;
    logic              busy_q,    busy_d;
    logic              valid_q,   valid_d;

    // One double-dabble step: correct each BCD digit, then shift {bcd, bin} left.
    logic [SW-1:0]     adj;
    logic [SW-1:0]     shift_iter;
    logic              last_iter;

`ifdef SCORE_BCD_SEG_EN
    logic [7*DIGITS-1:0] seg1_q, seg1_d;
    logic [7*DIGITS-1:0] seg2_q, seg2_d;

    function automatic logic [7*DIGITS-1:0] to_seg(input logic [BW-1:0] b);
        logic [7*DIGITS-1:0] s;
        s = '0;
        for (int d = 0; d < DIGITS; d++) begin
            case (b[4*d +: 4])
                4'd0:    s[7*d +: 7] = 7'b1000000;
                4'd1:    s[7*d +: 7] = 7'b1111001;
                4'd2:    s[7*d +: 7] = 7'b0100100;
                4'd3:    s[7*d +: 7] = 7'b0110000;
                4'd4:    s[7*d +: 7] = 7'b0011001;
                4'd5:    s[7*d +: 7] = 7'b0010010;
                4'd6:    s[7*d +: 7] = 7'b0000010;
                4'd7:    s[7*d +: 7] = 7'b1111000;
                4'd8:    s[7*d +: 7] = 7'b0000000;
                4'd9:    s[7*d +: 7] = 7'b0010000;
                default: s[7*d +: 7] = 7'b1111111;
            endcase
        end
        return s;
    endfunction
`endif

    always_comb begin
        adj = shift_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_q[IN_WIDTH + 4*d +: 4] >= 4'd5) begin
                adj[IN_WIDTH + 4*d +: 4] = shift_q[IN_WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        shift_iter = {adj[SW-2:0], 1'b0};
        last_iter  = (cnt_q == CW'(IN_WIDTH - 1));
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        snap2_d   = snap2_q;
        shift_d   = shift_q;
        temp1_d   = temp1_q;
        bcd1_d    = bcd1_q;
        bcd2_d    = bcd2_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
`ifdef SCORE_BCD_SEG_EN
        seg1_d    = seg1_q;
        seg2_d    = seg2_q;
`endif
        case (state_q)
            IDLE: begin
                if (update_score) begin
                    snap2_d = score2;
                    shift_d = {{BW{1'b0}}, score1};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV1;
                end
            end
            CONV1: begin
                if (update_score) pending_d = 1'b1;
                shift_d = shift_iter;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    temp1_d = shift_iter[SW-1:IN_WIDTH];
                    shift_d = {{BW{1'b0}}, snap2_q};
                    cnt_d   = '0;
                    state_d = CONV2;
                end
            end
            CONV2: begin
                if (update_score) pending_d = 1'b1;
                shift_d = shift_iter;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    // Both results are published together so the display never tears.
                    bcd1_d  = temp1_q;
                    bcd2_d  = shift_iter[SW-1:IN_WIDTH];
`ifdef SCORE_BCD_SEG_EN
                    seg1_d  = to_seg(temp1_q);
                    seg2_d  = to_seg(shift_iter[SW-1:IN_WIDTH]);
`endif
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pending_q || update_score) begin
                    pending_d = 1'b0;
                    snap2_d   = score2;
                    shift_d   = {{BW{1'b0}}, score1};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CONV1;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            snap2_q   <= '0;
            shift_q   <= '0;
            temp1_q   <= '0;
            bcd1_q    <= '0;
            bcd2_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef SCORE_BCD_SEG_EN
            seg1_q    <= {DIGITS{7'b1000000}};
            seg2_q    <= {DIGITS{7'b1000000}};
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            snap2_q   <= snap2_d;
            shift_q   <= shift_d;
            temp1_q   <= temp1_d;
            bcd1_q    <= bcd1_d;
            bcd2_q    <= bcd2_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
`ifdef SCORE_BCD_SEG_EN
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
`endif
        end
    end

    assign bcd1  = bcd1_q;
    assign bcd2  = bcd2_q;
    assign busy  = busy_q;
    assign valid = valid_q;
`ifdef SCORE_BCD_SEG_EN
    assign seg1  = seg1_q;
    assign seg2  = seg2_q;
`endif

endmodule
